// File: rtl/mesi_isc_broad_snoop_cntl_pkg.sv
// Shared definitions for the broadcast snoop controller: bus widths,
// cbus command and broadcast type encodings, and the FSM state type.
package mesi_isc_broad_snoop_cntl_pkg;

    localparam int CBUS_CMD_WIDTH   = 3;
    localparam int ADDR_WIDTH       = 32;
    localparam int BROAD_TYPE_WIDTH = 2;
    localparam int BROAD_ID_WIDTH   = 7;
    localparam int CPU_COUNT        = 4;

    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_CMD_NOP      = 3'd0;
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_CMD_WR_SNOOP = 3'd1;
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_CMD_RD_SNOOP = 3'd2;
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_CMD_EN_WR    = 3'd3;
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_CMD_EN_RD    = 3'd4;

    localparam logic [BROAD_TYPE_WIDTH-1:0] BREQ_TYPE_NOP = 2'd0;
    localparam logic [BROAD_TYPE_WIDTH-1:0] BREQ_TYPE_WR  = 2'd1;
    localparam logic [BROAD_TYPE_WIDTH-1:0] BREQ_TYPE_RD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SNOOP  = 2'd1,
        ENABLE = 2'd2
    } state_t;

    // Only WR and RD broadcasts need a snoop round; anything else is dropped.
    function automatic logic is_coherent(input logic [BROAD_TYPE_WIDTH-1:0] broad_type);
        return (broad_type == BREQ_TYPE_WR) || (broad_type == BREQ_TYPE_RD);
    endfunction

endpackage

// File: rtl/mesi_isc_broad_snoop_cntl_if.sv
// Bundle of the broadcast FIFO head, FIFO pop strobe and the four-CPU cbus.
// master is the snoop controller's view, slave is the surrounding system.
interface mesi_isc_broad_snoop_cntl_if
    import mesi_isc_broad_snoop_cntl_pkg::*;
();

    logic                                  broad_fifo_status_empty_i;
    logic [ADDR_WIDTH-1:0]                 broad_addr_i;
    logic [BROAD_TYPE_WIDTH-1:0]           broad_type_i;
    logic [1:0]                            broad_cpu_id_i;
    logic [BROAD_ID_WIDTH-1:0]             broad_id_i;
    logic [CPU_COUNT-1:0]                  cbus_ack_array_i;
    logic                                  broad_fifo_rd_o;
    logic [ADDR_WIDTH-1:0]                 cbus_addr_o;
    logic [CPU_COUNT*CBUS_CMD_WIDTH-1:0]   cbus_cmd_array_o;
    logic [BROAD_ID_WIDTH-1:0]             broad_id_o;
    logic                                  busy_o;

    modport master (
        input  broad_fifo_status_empty_i, broad_addr_i, broad_type_i,
               broad_cpu_id_i, broad_id_i, cbus_ack_array_i,
        output broad_fifo_rd_o, cbus_addr_o, cbus_cmd_array_o,
               broad_id_o, busy_o
    );

    modport slave (
        output broad_fifo_status_empty_i, broad_addr_i, broad_type_i,
               broad_cpu_id_i, broad_id_i, cbus_ack_array_i,
        input  broad_fifo_rd_o, cbus_addr_o, cbus_cmd_array_o,
               broad_id_o, busy_o
    );

endinterface

// File: rtl/mesi_isc_broad_snoop_cntl.sv
// Broadcast snoop controller: pops one broadcast from the FIFO, snoops the
// three other CPUs, then enables the originator, one broadcast at a time.
module mesi_isc_broad_snoop_cntl
    import mesi_isc_broad_snoop_cntl_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    mesi_isc_broad_snoop_cntl_if.master  bus
);

    state_t                        state;
    state_t                        next_state;
    logic [ADDR_WIDTH-1:0]         addr_q;
    logic [BROAD_ID_WIDTH-1:0]     id_q;
    logic [BROAD_TYPE_WIDTH-1:0]   type_q;
    logic [1:0]                    cpu_q;
    logic [CPU_COUNT-1:0]          mask_q;
    logic [CPU_COUNT-1:0]          mask_merged;
    logic                          pop;
    logic                          pop_valid;
    logic                          snoop_done;
    logic                          enable_ack;
    logic [CBUS_CMD_WIDTH-1:0]     snoop_cmd;
    logic [CBUS_CMD_WIDTH-1:0]     enable_cmd;

    assign pop         = (state == IDLE) && !bus.broad_fifo_status_empty_i;
    assign pop_valid   = pop && is_coherent(bus.broad_type_i);
    assign mask_merged = mask_q | bus.cbus_ack_array_i;
    assign snoop_done  = (state == SNOOP) && (mask_merged == {CPU_COUNT{1'b1}});
    assign enable_ack  = (state == ENABLE) && bus.cbus_ack_array_i[cpu_q];
    assign snoop_cmd   = (bus.broad_type_i == BREQ_TYPE_WR) ? CBUS_CMD_WR_SNOOP : CBUS_CMD_RD_SNOOP;
    assign enable_cmd  = (type_q == BREQ_TYPE_WR) ? CBUS_CMD_EN_WR : CBUS_CMD_EN_RD;

    assign bus.broad_fifo_rd_o = pop;
    assign bus.cbus_addr_o     = addr_q;
    assign bus.broad_id_o      = id_q;
    assign bus.busy_o          = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: pop, wait for all snoop acks, wait for the enable ack.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pop_valid)  next_state = SNOOP;
            SNOOP:   if (snoop_done) next_state = ENABLE;
            ENABLE:  if (enable_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the FIFO head on every pop; held until the next pop, even for NOPs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            id_q   <= '0;
            type_q <= BREQ_TYPE_NOP;
            cpu_q  <= '0;
        end else if (pop) begin
            addr_q <= bus.broad_addr_i;
            id_q   <= bus.broad_id_i;
            type_q <= bus.broad_type_i;
            cpu_q  <= bus.broad_cpu_id_i;
        end
    end

    // Ack mask: originator pre-set so its own snoop ack never counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            case (state)
                IDLE:    if (pop_valid) mask_q <= 4'b0001 << bus.broad_cpu_id_i;
                SNOOP:   mask_q <= mask_merged;
                ENABLE:  if (enable_ack) mask_q <= '0;
                default: mask_q <= '0;
            endcase
        end
    end

    for (genvar n = 0; n < CPU_COUNT; n++) begin : g_cpu
        logic [CBUS_CMD_WIDTH-1:0] cmd_q;

        // Per-CPU command register: snoop, drop on own ack, enable originator last.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cmd_q <= CBUS_CMD_NOP;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop_valid) begin
                            cmd_q <= (bus.broad_cpu_id_i == 2'(n)) ? CBUS_CMD_NOP : snoop_cmd;
                        end
                    end
                    SNOOP: begin
                        if (snoop_done) begin
                            cmd_q <= (cpu_q == 2'(n)) ? enable_cmd : CBUS_CMD_NOP;
                        end else if (bus.cbus_ack_array_i[n]) begin
                            cmd_q <= CBUS_CMD_NOP;
                        end
                    end
                    ENABLE: begin
                        if (enable_ack) cmd_q <= CBUS_CMD_NOP;
                    end
                    default: cmd_q <= CBUS_CMD_NOP;
                endcase
            end
        end

        assign bus.cbus_cmd_array_o[n*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = cmd_q;
    end

endmodule

// File: tb/tb_mesi_isc_broad_snoop_cntl.sv
// Self-checking bench for the broadcast snoop controller. The reference model
// tracks the in-flight broadcast as a set of CPUs still owing a snoop ack plus
// a pending-enable flag, and a queue stands in for the broadcast FIFO.
module tb_mesi_isc_broad_snoop_cntl;

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [1:0]  cpu;
        logic [6:0]  id;
    } entry_t;

    logic clk;
    logic rst_n;

    mesi_isc_broad_snoop_cntl_if bus ();

    mesi_isc_broad_snoop_cntl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int rd_pulses  = 0;

    entry_t      fifo_q[$];
    bit          snoop_pend[4];
    bit          en_pend;
    int          m_cpu;
    int          m_type;
    logic [31:0] m_addr;
    logic [6:0]  m_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison point: counts every check and reports any difference.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_busy();
        bit b;
        b = en_pend;
        for (int n = 0; n < 4; n++) b = b | snoop_pend[n];
        return b;
    endfunction

    // Expected command bus from the pending sets (encodings taken from the
    // command table: NOP 0, WR_SNOOP 1, RD_SNOOP 2, EN_WR 3, EN_RD 4).
    function automatic logic [11:0] exp_cmds();
        logic [11:0] v;
        int c;
        v = '0;
        for (int n = 0; n < 4; n++) begin
            c = 0;
            if (snoop_pend[n])               c = (m_type == 1) ? 1 : 2;
            else if (en_pend && n == m_cpu)  c = (m_type == 1) ? 3 : 4;
            v = v | (12'(c) << (3 * n));
        end
        return v;
    endfunction

    // Advance the reference model by one clock edge given the acks presented.
    task automatic model_step(input logic [3:0] ack);
        entry_t e;
        bit any_left;
        if (!exp_busy()) begin
            if (fifo_q.size() > 0) begin
                e      = fifo_q.pop_front();
                m_addr = e.addr;
                m_id   = e.id;
                m_type = int'(e.typ);
                m_cpu  = int'(e.cpu);
                if (m_type == 1 || m_type == 2) begin
                    for (int n = 0; n < 4; n++) snoop_pend[n] = (n != m_cpu);
                end
            end
        end else if (!en_pend) begin
            any_left = 1'b0;
            for (int n = 0; n < 4; n++) begin
                if (ack[n]) snoop_pend[n] = 1'b0;
                any_left = any_left | snoop_pend[n];
            end
            if (!any_left) en_pend = 1'b1;
        end else if (ack[m_cpu]) begin
            en_pend = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) snoop_pend[n] = 1'b0;
        en_pend = 1'b0;
        m_addr  = '0;
        m_id    = '0;
        m_type  = 0;
        m_cpu   = 0;
    endtask

    task automatic check_output();
        chk("busy", 64'(bus.busy_o), 64'(exp_busy()));
        chk("cmds", 64'(bus.cbus_cmd_array_o), 64'(exp_cmds()));
        chk("addr", 64'(bus.cbus_addr_o), 64'(m_addr));
        chk("id",   64'(bus.broad_id_o), 64'(m_id));
    endtask

    // One clock cycle: present FIFO head and acks, check the pop strobe,
    // advance the model on the edge, check registered outputs on the negedge.
    task automatic apply_stimulus(input logic [3:0] ack);
        bus.broad_fifo_status_empty_i = (fifo_q.size() == 0);
        if (fifo_q.size() > 0) begin
            bus.broad_type_i   = fifo_q[0].typ;
            bus.broad_addr_i   = fifo_q[0].addr;
            bus.broad_cpu_id_i = fifo_q[0].cpu;
            bus.broad_id_i     = fifo_q[0].id;
        end else begin
            bus.broad_type_i   = '0;
            bus.broad_addr_i   = '0;
            bus.broad_cpu_id_i = '0;
            bus.broad_id_i     = '0;
        end
        bus.cbus_ack_array_i = ack;
        #1;
        chk("rd", 64'(bus.broad_fifo_rd_o), 64'(!exp_busy() && fifo_q.size() > 0));
        if (bus.broad_fifo_rd_o === 1'b1) rd_pulses++;
        @(posedge clk);
        model_step(ack);
        @(negedge clk);
        check_output();
    endtask

    task automatic push(input logic [1:0] typ, input logic [31:0] addr,
                        input logic [1:0] cpu, input logic [6:0] id);
        entry_t e;
        e.typ = typ; e.addr = addr; e.cpu = cpu; e.id = id;
        fifo_q.push_back(e);
    endtask

    // Asynchronous reset applied away from the clock edge, checked at once.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.broad_fifo_status_empty_i = 1'b1;
        bus.cbus_ack_array_i = '0;
        model_reset();
        #1;
        chk("rst_rd", 64'(bus.broad_fifo_rd_o), 64'd0);
        check_output();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] cpus[3];
        logic [3:0] others;
        int guard;

        rst_n = 1'b0;
        bus.broad_fifo_status_empty_i = 1'b1;
        bus.broad_addr_i = '0;
        bus.broad_type_i = '0;
        bus.broad_cpu_id_i = '0;
        bus.broad_id_i = '0;
        bus.cbus_ack_array_i = '0;
        model_reset();

        @(negedge clk);
        do_reset();

        $display("[TB] idle with empty FIFO");
        for (int i = 0; i < 20; i++) apply_stimulus(4'b0000);

        $display("[TB] write broadcast");
        push(2'd1, 32'h0000_1000, 2'd1, 7'h05);
        apply_stimulus(4'b0000);
        chk("wr_snoop_cmds", 64'(bus.cbus_cmd_array_o), 64'({3'd1, 3'd1, 3'd0, 3'd1}));
        chk("wr_addr", 64'(bus.cbus_addr_o), 64'h1000);
        chk("wr_id", 64'(bus.broad_id_o), 64'h05);
        apply_stimulus(4'b1101);
        chk("wr_enable_cmds", 64'(bus.cbus_cmd_array_o), 64'({3'd0, 3'd0, 3'd3, 3'd0}));
        apply_stimulus(4'b0010);
        chk("wr_idle", 64'(bus.busy_o), 64'd0);
        chk("wr_addr_held", 64'(bus.cbus_addr_o), 64'h1000);

        $display("[TB] read broadcast with staggered acks");
        push(2'd2, 32'hCAFE_0040, 2'd3, 7'h2A);
        apply_stimulus(4'b0000);
        apply_stimulus(4'b1000);
        apply_stimulus(4'b0100);
        apply_stimulus(4'b0001);
        chk("rd_still_snoop", 64'(bus.cbus_cmd_array_o), 64'({3'd0, 3'd0, 3'd2, 3'd0}));
        apply_stimulus(4'b0010);
        chk("rd_enable_cmds", 64'(bus.cbus_cmd_array_o), 64'({3'd4, 3'd0, 3'd0, 3'd0}));
        apply_stimulus(4'b0111);
        apply_stimulus(4'b1000);

        $display("[TB] NOP entry followed by a write");
        push(2'd0, 32'h0000_2222, 2'd2, 7'h11);
        push(2'd1, 32'h0000_3333, 2'd0, 7'h12);
        apply_stimulus(4'b0000);
        chk("nop_stays_idle", 64'(bus.busy_o), 64'd0);
        apply_stimulus(4'b0000);
        apply_stimulus(4'b1110);
        apply_stimulus(4'b0001);

        $display("[TB] three back-to-back broadcasts");
        rd_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            cpus[i] = 2'($urandom_range(0, 3));
            push(2'($urandom_range(1, 2)), $urandom, cpus[i], 7'($urandom));
        end
        for (int i = 0; i < 3; i++) begin
            others = 4'b1111 & ~(4'b0001 << cpus[i]);
            apply_stimulus(4'b0000);
            apply_stimulus(others);
            apply_stimulus(4'b0001 << cpus[i]);
        end
        chk("three_pops", 64'(rd_pulses), 64'd3);

        $display("[TB] reset during snoop");
        push(2'd1, 32'h0000_4444, 2'd2, 7'h21);
        push(2'd2, 32'h0000_5555, 2'd0, 7'h22);
        apply_stimulus(4'b0000);
        apply_stimulus(4'b0001);
        do_reset();
        apply_stimulus(4'b0000);
        chk("post_reset_addr", 64'(bus.cbus_addr_o), 64'h5555);
        apply_stimulus(4'b1110);
        apply_stimulus(4'b0001);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 4) begin
                push(2'($urandom_range(0, 2)), $urandom, 2'($urandom_range(0, 3)), 7'($urandom));
            end
            apply_stimulus(4'($urandom_range(0, 15)));
        end
        guard = 0;
        while ((exp_busy() || fifo_q.size() > 0) && guard < 100) begin
            apply_stimulus(4'b1111);
            guard++;
        end
        chk("drained", 64'(guard < 100), 64'd1);
        chk("final_idle", 64'(bus.busy_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mesi_isc_broad_snoop_cntl.md
Name: mesi_isc_broad_snoop_cntl

Overview:
- Downstream consumer of the broadcast-request FIFO, which the breq FIFO controller writes.
- Pops one broadcast at a time (address, type, originating CPU, ID) and drives a snoop command onto the cbus of the three other CPUs.
- Waits for a snoop ack from each of those three, then sends the originating CPU an enable (EN_WR/EN_RD) and waits for its ack.
- Serialises coherence broadcasts: only one is in flight at a time.

Parameters:
- CBUS_CMD_WIDTH, 3, width of one CPU's cbus command.
- ADDR_WIDTH, 32, broadcast and cbus address width.
- BROAD_TYPE_WIDTH, 2, broadcast type width.
- BROAD_ID_WIDTH, 7, broadcast ID width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- broad_fifo_status_empty_i  in  1  broad FIFO empty.
- broad_addr_i  in  ADDR_WIDTH  FIFO head address; first-word fall-through, valid while not empty.
- broad_type_i  in  BROAD_TYPE_WIDTH  FIFO head type (NOP/WR/RD).
- broad_cpu_id_i  in  2  FIFO head originating CPU.
- broad_id_i  in  BROAD_ID_WIDTH  FIFO head broadcast ID.
- cbus_ack_array_i  in  4  per-CPU single-cycle ack; bit n belongs to CPU n.
- broad_fifo_rd_o  out  1  pop the FIFO head.
- cbus_addr_o  out  ADDR_WIDTH  address of the active broadcast.
- cbus_cmd_array_o  out  4*CBUS_CMD_WIDTH  per-CPU command; CPU n occupies slice [(n+1)*W-1:n*W].
- broad_id_o  out  BROAD_ID_WIDTH  ID of the active broadcast.
- busy_o  out  1  a broadcast is in flight (state is not IDLE).

Behaviour:
- Reset:
  - Asynchronous on rst_n low. State returns to IDLE.
  - cbus_cmd_array_o is all NOP, cbus_addr_o = 0, broad_id_o = 0, busy_o = 0, ack mask = 0.
  - broad_fifo_rd_o = 0 because it is gated by IDLE and empty.
  - Reset mid-broadcast drops the popped entry. The FIFO is not touched.
- States: IDLE, SNOOP, ENABLE.
- IDLE:
  - broad_fifo_rd_o = ~broad_fifo_status_empty_i. This is the only combinational output, asserted in IDLE only, for exactly one cycle per entry.
  - On the popping edge, register addr, type, cpu_id and id.
  - Type NOP: discard the entry and stay in IDLE.
  - Type WR or RD, originator k: go to SNOOP, pre-set the ack mask bit k, and load every CPU n != k with WR_SNOOP or RD_SNOOP. CPU k is loaded with NOP.
  - Snoop commands are visible one cycle after the pop cycle.
- SNOOP:
  - When cbus_ack_array_i[n] = 1 for n != k with the mask bit clear: set mask bit n. CPU n's command becomes NOP from the next cycle.
  - Acks on CPU k, or on already-acked CPUs, are ignored.
  - Acks may arrive simultaneously or staggered, in any order.
  - On the edge where the mask becomes 4'b1111, go to ENABLE and load CPU k with EN_WR (type WR) or EN_RD (type RD). Every other CPU is NOP.
- ENABLE:
  - On the edge where cbus_ack_array_i[k] = 1, CPU k's command becomes NOP, the mask clears, and the state returns to IDLE.
  - Acks from other CPUs are ignored.
  - The next pop can occur in the cycle after the return to IDLE.
- Command and ack rules:
  - A command never persists past the cycle following its ack.
  - Every command output is registered.
- cbus_addr_o and broad_id_o:
  - Hold their values until the next pop.
  - They are not cleared on return to IDLE.
- No timeout. The block waits indefinitely for acks.
- Minimum occupancy per WR/RD broadcast, with immediate acks: pop cycle, 1 snoop cycle, 1 enable cycle, then back in IDLE.

Decomposition:
- The shared define package holds CBUS_CMD encodings: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
- The same package holds BREQ_TYPE encodings: NOP=0, WR=1, RD=2.
- It also holds the state enum typedef (IDLE/SNOOP/ENABLE).
- Single module, no sub-module. Per-CPU command registers are built with a generate loop.

Test Plan:
- Empty FIFO held for 20 cycles -> broad_fifo_rd_o = 0, busy_o = 0, all commands NOP.
- Write broadcast:
  - Stimulus: head {WR, addr 0x0000_1000, cpu 1, id 0x05}; acks from CPUs 0, 2, 3 in one cycle, then ack 1.
  - Required response: rd pulses 1 cycle; next cycle CPUs 0/2/3 = WR_SNOOP and CPU1 = NOP; then CPU1 = EN_WR; then IDLE.
  - cbus_addr_o = 0x1000 and broad_id_o = 0x05 throughout.
- Read broadcast:
  - Stimulus: head {RD, cpu 3}; staggered acks 2, 0, 1 on separate cycles; ack 3 injected during SNOOP.
  - Required response: each CPU drops to NOP the cycle after its own ack; the early ack 3 is ignored; EN_RD reaches CPU3 only after ack 1.
- NOP entry at the head -> popped in 1 cycle, no snoop commands, state stays IDLE, next entry popped the following cycle.
- Three entries back-to-back with immediate acks -> exactly 3 rd pulses, each separated by a full SNOOP+ENABLE sequence; busy_o never rises while a command is pending elsewhere.
- rst_n low during SNOOP -> outputs reach reset values immediately; after release the next FIFO entry is popped and the dropped broadcast is not resumed.
